// File: rtl/cpu6_pkg.sv
// Shared definitions for the 6-bit CPU: memory geometry, opcodes, NOP word
// and the boot loader state encoding.
package cpu6_pkg;

  localparam int AW = 6;
  localparam int DW = 10;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_JC  = 4'hB;
  localparam logic [3:0] OP_OUT = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [DW-1:0] NOP_WORD = {OP_NOP, 6'd0};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HI   = 3'd1,
    ST_LO   = 3'd2,
    ST_CHK  = 3'd3,
    ST_FILL = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } loader_state_e;

endpackage

// File: rtl/imem_loader.sv
// Boot loader: byte stream -> 10-bit instruction writes, NOP fill, then RUN.
// Optional check byte after the last word when LOADER_CHECKSUM_EN is defined.
//
// state | meaning
// IDLE  | waiting for count byte (N-1 in DIN[5:0])
// HI    | waiting for instr[9:8] byte
// LO    | waiting for instr[7:0] byte, then write
// CHK   | waiting for check byte (checksum build only)
// FILL  | writing NOP_WORD to addresses N..63
// DONE  | RUN asserted until START
// ERR   | ERR asserted until START
module imem_loader #(
  parameter int              AW       = cpu6_pkg::AW,
  parameter int              DW       = cpu6_pkg::DW,
  parameter logic [DW-1:0]   NOP_WORD = cpu6_pkg::NOP_WORD
) (
  input  logic          CK,
  input  logic          RB,
  input  logic          START,
  input  logic [7:0]    DIN,
  input  logic          DVALID,
  output logic          DREADY,
  output logic          WE,
  output logic [AW-1:0] WA,
  output logic [DW-1:0] WD,
  output logic          RUN,
  output logic          ERR
);
  import cpu6_pkg::*;

  loader_state_e state_q;
  logic [AW-1:0] cnt_q;
  logic [AW-1:0] last_q;
  logic [1:0]    hi_q;
  logic          we_q;
  logic [AW-1:0] wa_q;
  logic [DW-1:0] wd_q;
  logic          run_q;
  logic          err_q;
  logic          ready;
  logic          xfer;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic [7:0] sum_d;
  assign sum_d = sum_q + DIN;
`endif

  assign ready  = (state_q == ST_IDLE) || (state_q == ST_HI) ||
                  (state_q == ST_LO)   || (state_q == ST_CHK);
  assign xfer   = DVALID && ready;

  assign DREADY = ready;
  assign WE     = we_q;
  assign WA     = wa_q;
  assign WD     = wd_q;
  assign RUN    = run_q;
  assign ERR    = err_q;

  always_ff @(posedge CK or negedge RB) begin
    if (!RB) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
      hi_q    <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      // START wins over any byte presented in the same cycle
      if (START) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        run_q   <= 1'b0;
        err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        sum_q   <= '0;
`endif
      end else begin
        case (state_q)
          ST_IDLE: if (xfer) begin
            if (DIN[7:6] != 2'b00) begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end else begin
              last_q  <= DIN[5:0];
              cnt_q   <= '0;
              state_q <= ST_HI;
`ifdef LOADER_CHECKSUM_EN
              sum_q   <= sum_d;
`endif
            end
          end
          ST_HI: if (xfer) begin
            if (DIN[7:2] != 6'd0) begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end else begin
              hi_q    <= DIN[1:0];
              state_q <= ST_LO;
`ifdef LOADER_CHECKSUM_EN
              sum_q   <= sum_d;
`endif
            end
          end
          ST_LO: if (xfer) begin
            we_q  <= 1'b1;
            wa_q  <= cnt_q;
            wd_q  <= {hi_q, DIN};
            cnt_q <= cnt_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum_q <= sum_d;
            state_q <= (cnt_q == last_q) ? ST_CHK : ST_HI;
`else
            // a full 64-word program has nothing left to pad
            if (cnt_q == last_q) state_q <= (last_q == '1) ? ST_DONE : ST_FILL;
            else                 state_q <= ST_HI;
`endif
          end
`ifdef LOADER_CHECKSUM_EN
          ST_CHK: if (xfer) begin
            if (sum_d == 8'h00) begin
              state_q <= (last_q == '1) ? ST_DONE : ST_FILL;
            end else begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end
          end
`endif
          ST_FILL: begin
            we_q  <= 1'b1;
            wa_q  <= cnt_q;
            wd_q  <= NOP_WORD;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == '1) state_q <= ST_DONE;
          end
          // RUN rises one cycle after the final write, so WE and RUN never overlap
          ST_DONE: run_q <= 1'b1;
          ST_ERR:  err_q <= 1'b1;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of single-word loads plus
// hand-written multi-cycle sequences (fill, full load, errors, START abort).
module tb_imem_loader;
  import cpu6_pkg::*;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  logic       CK = 1'b0;
  logic       RB = 1'b1;
  logic       START = 1'b0;
  logic [7:0] DIN = 8'h00;
  logic       DVALID = 1'b0;
  logic       DREADY;
  logic       WE;
  logic [5:0] WA;
  logic [9:0] WD;
  logic       RUN;
  logic       ERR;

  imem_loader dut (
    .CK(CK), .RB(RB), .START(START), .DIN(DIN), .DVALID(DVALID),
    .DREADY(DREADY), .WE(WE), .WA(WA), .WD(WD), .RUN(RUN), .ERR(ERR)
  );

  always #5 CK = ~CK;

  int checks = 0;
  int errors = 0;

  int         cyc = 0;
  int         overlap = 0;
  int         run_rise = -1;
  logic       run_prev = 1'b0;
  logic [5:0] log_a[$];
  logic [9:0] log_d[$];
  int         log_c[$];

  always @(negedge CK) begin
    cyc++;
    if (WE === 1'b1) begin
      log_a.push_back(WA);
      log_d.push_back(WD);
      log_c.push_back(cyc);
    end
    if (WE === 1'b1 && RUN === 1'b1) overlap++;
    if (RUN === 1'b1 && run_prev !== 1'b1) run_rise = cyc;
    run_prev = RUN;
  end

  logic [7:0] prog[$];
  logic [9:0] exp_w[$];

  typedef struct {
    logic [7:0] cb;
    logic [7:0] hb;
    logic [7:0] lb;
    bit         exp_err;
    logic [9:0] w0;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge CK);
    while (DREADY !== 1'b1 && t < 50) begin
      @(negedge CK);
      t++;
    end
    if (DREADY !== 1'b1) chk("dready_wait", {31'd0, DREADY}, 32'd1);
    DIN    = b;
    DVALID = 1'b1;
    @(negedge CK);
    DVALID = 1'b0;
  endtask

  task automatic send_prog(input bit add_chk);
    logic [7:0] s;
    s = 8'h00;
    foreach (prog[i]) begin
      s = s + prog[i];
      send_byte(prog[i]);
    end
    if (add_chk && CHK_ON) send_byte(8'h00 - s);
  endtask

  task automatic wait_end(input string name);
    int t = 0;
    while (!(RUN === 1'b1 || ERR === 1'b1) && t < 300) begin
      @(negedge CK);
      t++;
    end
    chk({name, "_end"}, {31'd0, (RUN === 1'b1 || ERR === 1'b1)}, 32'd1);
    #1;
  endtask

  task automatic pulse_start();
    @(negedge CK);
    START = 1'b1;
    @(negedge CK);
    START = 1'b0;
    #1;
  endtask

  // Expect 64 sequential writes: exp_w at 0..n-1, NOP_WORD after, then RUN.
  task automatic check_full(input string name, input int base);
    int bad = 0;
    int n;
    int last_c;
    logic [9:0] ed;
    n = exp_w.size();
    chk({name, "_nwr"}, log_a.size() - base, 32'd64);
    for (int k = 0; k < 64; k++) begin
      ed = (k < n) ? exp_w[k] : NOP_WORD;
      if (base + k >= log_a.size()) bad++;
      else if (log_a[base+k] !== 6'(k) || log_d[base+k] !== ed) bad++;
    end
    chk({name, "_words"}, bad, 32'd0);
    last_c = (log_a.size() > base) ? log_c[log_c.size()-1] : -100;
    chk({name, "_run_after_we"}, run_rise, last_c + 1);
    if (n < 64 && log_a.size() >= base + 64)
      chk({name, "_fill_contig"}, log_c[base+63] - log_c[base+n], 63 - n);
    chk({name, "_run"}, {31'd0, RUN}, 32'd1);
    chk({name, "_dready"}, {31'd0, DREADY}, 32'd0);
    chk({name, "_err"}, {31'd0, ERR}, 32'd0);
    chk({name, "_we_run_overlap"}, overlap, 32'd0);
  endtask

  initial begin
    int base;
    logic [9:0] w;

    vt[0] = '{8'h00, 8'h00, 8'h00, 1'b0, 10'h000};
    vt[1] = '{8'h00, 8'h03, 8'hFF, 1'b0, 10'h3FF};
    vt[2] = '{8'h00, 8'h02, 8'h5A, 1'b0, 10'h25A};
    vt[3] = '{8'h40, 8'h00, 8'h00, 1'b1, 10'h000};
    vt[4] = '{8'hC5, 8'h00, 8'h00, 1'b1, 10'h000};
    vt[5] = '{8'h00, 8'h04, 8'h11, 1'b1, 10'h000};
    vt[6] = '{8'h00, 8'h80, 8'h11, 1'b1, 10'h000};
    vt[7] = '{8'h00, 8'h01, 8'h80, 1'b0, 10'h180};

    #2 RB = 1'b0;
    repeat (3) @(negedge CK);
    chk("rst_we",     {31'd0, WE},     32'd0);
    chk("rst_wa",     {26'd0, WA},     32'd0);
    chk("rst_wd",     {22'd0, WD},     32'd0);
    chk("rst_run",    {31'd0, RUN},    32'd0);
    chk("rst_err",    {31'd0, ERR},    32'd0);
    chk("rst_dready", {31'd0, DREADY}, 32'd1);
    RB = 1'b1;

    // three words then NOP fill 3..63
    base  = log_a.size();
    prog  = '{8'h02, 8'h01, 8'hFF, 8'h00, 8'h05, 8'h03, 8'hC0};
    exp_w = '{10'h1FF, 10'h005, 10'h3C0};
    send_prog(1'b1);
    wait_end("t1");
    check_full("t1", base);

    // single-word table
    for (int i = 0; i < 8; i++) begin
      pulse_start();
      base = log_a.size();
      if (vt[i].cb[7:6] != 2'b00)      prog = '{vt[i].cb};
      else if (vt[i].hb[7:2] != 6'd0)  prog = '{vt[i].cb, vt[i].hb};
      else                             prog = '{vt[i].cb, vt[i].hb, vt[i].lb};
      send_prog(!vt[i].exp_err);
      wait_end($sformatf("tab%0d", i));
      chk($sformatf("tab%0d_err", i), {31'd0, ERR}, {31'd0, vt[i].exp_err});
      chk($sformatf("tab%0d_run", i), {31'd0, RUN}, {31'd0, !vt[i].exp_err});
      chk($sformatf("tab%0d_nwr", i), log_a.size() - base, vt[i].exp_err ? 32'd0 : 32'd64);
      if (!vt[i].exp_err)
        chk($sformatf("tab%0d_w0", i),
            (log_a.size() > base) ? {22'd0, log_d[base]} : 32'hDEAD, {22'd0, vt[i].w0});
    end

    // full 64-word load with DVALID toggling, no fill
    pulse_start();
    base  = log_a.size();
    prog  = '{8'h3F};
    exp_w = {};
    for (int k = 0; k < 64; k++) begin
      w = 10'((k * 37 + 5) & 32'h3FF);
      exp_w.push_back(w);
      prog.push_back({6'd0, w[9:8]});
      prog.push_back(w[7:0]);
    end
    send_prog(1'b1);
    wait_end("t2");
    check_full("t2", base);

    // bad count byte, then recovery via START
    pulse_start();
    base = log_a.size();
    send_byte(8'h40);
    #1;
    chk("t3_err",    {31'd0, ERR},    32'd1);
    chk("t3_dready", {31'd0, DREADY}, 32'd0);
    chk("t3_run",    {31'd0, RUN},    32'd0);
    chk("t3_nwr",    log_a.size() - base, 32'd0);
    pulse_start();
    chk("t3_err_clr", {31'd0, ERR},    32'd0);
    chk("t3_ready",   {31'd0, DREADY}, 32'd1);

    // bad HI byte after two good words
    base = log_a.size();
    prog = '{8'h04, 8'h01, 8'hAA, 8'h02, 8'h55, 8'h04};
    send_prog(1'b0);
    #1;
    chk("t4_err", {31'd0, ERR}, 32'd1);
    chk("t4_run", {31'd0, RUN}, 32'd0);
    chk("t4_nwr", log_a.size() - base, 32'd2);
    if (log_a.size() >= base + 2) begin
      chk("t4_w0", {22'd0, log_d[base]},   32'h1AA);
      chk("t4_a1", {26'd0, log_a[base+1]}, 32'd1);
      chk("t4_w1", {22'd0, log_d[base+1]}, 32'h255);
    end
    repeat (10) @(negedge CK);
    #1;
    chk("t4_nwr_hold", log_a.size() - base, 32'd2);
    chk("t4_run_hold", {31'd0, RUN}, 32'd0);

    // START collides with the LO byte of word 1
    pulse_start();
    base = log_a.size();
    prog = '{8'h01, 8'h03, 8'h11, 8'h02};
    send_prog(1'b0);
    @(negedge CK);
    DIN    = 8'h77;
    DVALID = 1'b1;
    START  = 1'b1;
    @(negedge CK);
    DVALID = 1'b0;
    START  = 1'b0;
    #1;
    chk("t5_we",     {31'd0, WE},     32'd0);
    chk("t5_dready", {31'd0, DREADY}, 32'd1);
    chk("t5_nwr",    log_a.size() - base, 32'd1);
    repeat (3) @(negedge CK);
    #1;
    chk("t5_nwr_hold", log_a.size() - base, 32'd1);
    base  = log_a.size();
    prog  = '{8'h00, 8'h01, 8'h23};
    exp_w = '{10'h123};
    send_prog(1'b1);
    wait_end("t5b");
    check_full("t5b", base);

`ifdef LOADER_CHECKSUM_EN
    pulse_start();
    base = log_a.size();
    prog = '{8'h00, 8'h01, 8'h23, 8'hDC};
    send_prog(1'b0);
    wait_end("t6a");
    check_full("t6a", base);
    pulse_start();
    base = log_a.size();
    prog = '{8'h00, 8'h01, 8'h23, 8'hDD};
    send_prog(1'b0);
    wait_end("t6b");
    chk("t6b_err", {31'd0, ERR}, 32'd1);
    chk("t6b_run", {31'd0, RUN}, 32'd0);
    repeat (5) @(negedge CK);
    #1;
    chk("t6b_nwr", log_a.size() - base, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
